// File: rtl/sn_defs.sv
// Shared definitions for the sorting-network slice.
// FSM encodings and default widths used by the cells and the unsort buffer.
package sn_defs;

    localparam int SN_DATA_WIDTH  = 8;
    localparam int SN_LABEL_WIDTH = 3;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/unsort_mem.sv
// Frame buffer for the unsort stage.
// One synchronous write port, one combinational read port.
module unsort_mem
    import sn_defs::*;
#(
    parameter int DATA_WIDTH  = SN_DATA_WIDTH,
    parameter int LABEL_WIDTH = SN_LABEL_WIDTH,
    parameter int N           = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [LABEL_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [LABEL_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]  rdata
);

    logic [DATA_WIDTH-1:0] mem [N];

    // Store a word in the slot named by its original position
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/label_unsort_buffer.sv
// Restores sorted (data, label) pairs to their original order.
// Fills a frame by label, then streams it out in index order.
module label_unsort_buffer
    import sn_defs::*;
#(
    parameter int DATA_WIDTH  = SN_DATA_WIDTH,
    parameter int LABEL_WIDTH = SN_LABEL_WIDTH,
    parameter int N           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic [LABEL_WIDTH-1:0] s_label,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [LABEL_WIDTH-1:0] m_index,
    output logic                   m_last,
    output logic                   err_dup,
    output logic                   err_range
);

    localparam logic [LABEL_WIDTH:0]   N_EXT    = (LABEL_WIDTH + 1)'(N);
    localparam logic [LABEL_WIDTH-1:0] LAST_IDX = LABEL_WIDTH'(N - 1);

    logic [0:0]             state;
    logic [N-1:0]           occ;
    logic [N-1:0]           hit;
    logic                   accept;
    logic                   in_range;
    logic                   wr;
    logic                   done;
    logic [LABEL_WIDTH-1:0] next_idx;
    logic [LABEL_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0]  rdata;

    assign s_ready  = (state == ST_FILL) && !rst;
    assign accept   = s_valid && s_ready;
    assign in_range = {1'b0, s_label} < N_EXT;
    assign wr       = accept && in_range;
    assign next_idx = m_index + 1'b1;
    assign done     = wr && (&(occ | hit));

    // Slot 0 is read on the completing write; the following slot while draining
    assign raddr = (state == ST_DRAIN && !m_last) ? next_idx : '0;

    // One-hot of the slot being written this cycle
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = wr && (s_label == LABEL_WIDTH'(i));
        end
    end

    unsort_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .LABEL_WIDTH(LABEL_WIDTH),
        .N          (N)
    ) u_mem (
        .clk  (clk),
        .we   (wr),
        .waddr(s_label),
        .wdata(s_data),
        .raddr(raddr),
        .rdata(rdata)
    );

    // Fill/drain control, occupancy tracking, output register and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            occ       <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            m_last    <= 1'b0;
            err_dup   <= 1'b0;
            err_range <= 1'b0;
        end else begin
            if (wr) begin
                occ <= occ | hit;
                if (|(occ & hit)) begin
                    err_dup <= 1'b1;
                end
            end
            if (accept && !in_range) begin
                err_range <= 1'b1;
            end
            if (done) begin
                state   <= ST_DRAIN;
                m_valid <= 1'b1;
                m_index <= '0;
                m_last  <= (N == 1);
                // The word completing the frame may itself belong in slot 0
                m_data  <= hit[0] ? s_data : rdata;
            end else if (state == ST_DRAIN && m_valid && m_ready) begin
                if (m_last) begin
                    state   <= ST_FILL;
                    occ     <= '0;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    m_index <= '0;
                end else begin
                    m_index <= next_idx;
                    m_data  <= rdata;
                    m_last  <= (next_idx == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_label_unsort_buffer.sv
// Testbench for label_unsort_buffer.
// Two instances: N=4 and N=3 (both LABEL_WIDTH=2), selected by sel.
module tb_label_unsort_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       s_valid;
    logic [7:0] s_data;
    logic [1:0] s_label;
    logic       m_ready;

    logic       a_s_ready, a_m_valid, a_m_last, a_err_dup, a_err_range;
    logic [7:0] a_m_data;
    logic [1:0] a_m_index;
    logic       b_s_ready, b_m_valid, b_m_last, b_err_dup, b_err_range;
    logic [7:0] b_m_data;
    logic [1:0] b_m_index;

    logic       o_s_ready, o_m_valid, o_m_last, o_err_dup, o_err_range;
    logic [7:0] o_m_data;
    logic [1:0] o_m_index;

    int cmp = 0;
    int err = 0;
    int cur_n;

    int exp_q[$];
    bit m_dup;
    bit m_rng;

    always #5 clk = ~clk;

    label_unsort_buffer #(.DATA_WIDTH(8), .LABEL_WIDTH(2), .N(4)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid(s_valid && !sel), .s_ready(a_s_ready),
        .s_data(s_data), .s_label(s_label),
        .m_valid(a_m_valid), .m_ready(m_ready && !sel),
        .m_data(a_m_data), .m_index(a_m_index), .m_last(a_m_last),
        .err_dup(a_err_dup), .err_range(a_err_range)
    );

    label_unsort_buffer #(.DATA_WIDTH(8), .LABEL_WIDTH(2), .N(3)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(s_valid && sel), .s_ready(b_s_ready),
        .s_data(s_data), .s_label(s_label),
        .m_valid(b_m_valid), .m_ready(m_ready && sel),
        .m_data(b_m_data), .m_index(b_m_index), .m_last(b_m_last),
        .err_dup(b_err_dup), .err_range(b_err_range)
    );

    assign o_s_ready   = sel ? b_s_ready   : a_s_ready;
    assign o_m_valid   = sel ? b_m_valid   : a_m_valid;
    assign o_m_data    = sel ? b_m_data    : a_m_data;
    assign o_m_index   = sel ? b_m_index   : a_m_index;
    assign o_m_last    = sel ? b_m_last    : a_m_last;
    assign o_err_dup   = sel ? b_err_dup   : a_err_dup;
    assign o_err_range = sel ? b_err_range : a_err_range;

    // Reference: last write per in-range label wins; frame = slots 0..n-1
    function automatic void ref_frame(input int dq[$], input int lq[$]);
        int mem[16];
        bit seen[16];
        for (int i = 0; i < 16; i++) begin
            mem[i] = 0;
            seen[i] = 1'b0;
        end
        for (int i = 0; i < dq.size(); i++) begin
            if (lq[i] >= cur_n) begin
                m_rng = 1'b1;
            end else begin
                if (seen[lq[i]]) m_dup = 1'b1;
                seen[lq[i]] = 1'b1;
                mem[lq[i]] = dq[i];
            end
        end
        exp_q.delete();
        for (int i = 0; i < cur_n; i++) exp_q.push_back(mem[i]);
    endfunction

    // Present one pair and hold it until accepted
    task automatic send(input int d, input int l);
        int t;
        bit hs;
        t = 0;
        hs = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'(d);
        s_label = 2'(l);
        while (!hs) begin
            @(negedge clk);
            hs = o_s_ready;
            @(posedge clk);
            #1;
            t++;
            if (!hs && t > 200) begin
                cmp++;
                err++;
                $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", o_s_ready, t);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    // Collect one frame; mode 0 = always ready, 1 = random ready
    task automatic drain(input int exp[$], input int mode, input string tag);
        int t;
        bit got;
        int n;
        n = exp.size();
        for (int k = 0; k < n; k++) begin
            t = 0;
            got = 1'b0;
            while (!got) begin
                m_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (o_m_valid) begin
                    cmp++;
                    if (o_m_data !== 8'(exp[k]) || o_m_index !== 2'(k)) begin
                        err++;
                        $display("FAIL %s_word%0d: data=%0d idx=%0d, required data=%0d idx=%0d",
                                 tag, k, o_m_data, o_m_index, exp[k], k);
                    end
                    cmp++;
                    if (o_m_last !== (k == n - 1)) begin
                        err++;
                        $display("FAIL %s_last%0d: m_last=%0b, required %0b", tag, k, o_m_last, (k == n - 1));
                    end
                    cmp++;
                    if (o_s_ready !== 1'b0) begin
                        err++;
                        $display("FAIL %s_sready_drain%0d: s_ready=%0b, required 0", tag, k, o_s_ready);
                    end
                    got = m_ready;
                end
                @(posedge clk);
                #1;
                t++;
                if (!got && t > 200) begin
                    cmp++;
                    err++;
                    $display("FAIL %s_drain_timeout: word %0d m_valid=%0b, required 1", tag, k, o_m_valid);
                    m_ready = 1'b0;
                    return;
                end
            end
        end
        m_ready = 1'b0;
        @(negedge clk);
        cmp++;
        if (o_m_valid !== 1'b0 || o_s_ready !== 1'b1) begin
            err++;
            $display("FAIL %s_end: m_valid=%0b s_ready=%0b, required 0/1", tag, o_m_valid, o_s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Send a whole frame, check completion latency and flags, then drain it
    task automatic run_frame(input int dq[$], input int lq[$], input int exp[$],
                             input bit edup, input bit erng, input int mode,
                             input int stall, input string tag);
        for (int i = 0; i < dq.size(); i++) begin
            if (i == dq.size() - 1) begin
                cmp++;
                if (o_m_valid !== 1'b0) begin
                    err++;
                    $display("FAIL %s_early_valid: m_valid=%0b, required 0", tag, o_m_valid);
                end
            end
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(dq[i], lq[i]);
        end
        cmp++;
        if (o_m_valid !== 1'b1) begin
            err++;
            $display("FAIL %s_latency: m_valid=%0b one cycle after last input, required 1", tag, o_m_valid);
        end
        cmp++;
        if (o_err_dup !== edup || o_err_range !== erng) begin
            err++;
            $display("FAIL %s_flags: err_dup=%0b err_range=%0b, required %0b/%0b",
                     tag, o_err_dup, o_err_range, edup, erng);
        end
        m_ready = 1'b0;
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            cmp++;
            if (o_m_valid !== 1'b1 || o_m_data !== 8'(exp[0]) ||
                o_m_index !== 2'd0 || o_s_ready !== 1'b0) begin
                err++;
                $display("FAIL %s_stall%0d: valid=%0b data=%0d idx=%0d s_ready=%0b, required 1/%0d/0/0",
                         tag, c, o_m_valid, o_m_data, o_m_index, o_s_ready, exp[0]);
            end
            @(posedge clk);
            #1;
        end
        drain(exp, mode, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_label = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp++;
        if (a_s_ready !== 1'b0 || b_s_ready !== 1'b0) begin
            err++;
            $display("FAIL reset_sready: a=%0b b=%0b, required 0", a_s_ready, b_s_ready);
        end
        cmp++;
        if (a_m_valid !== 1'b0 || a_m_data !== 8'd0 || a_m_index !== 2'd0 || a_m_last !== 1'b0) begin
            err++;
            $display("FAIL reset_outputs: valid=%0b data=%0d idx=%0d last=%0b, required 0",
                     a_m_valid, a_m_data, a_m_index, a_m_last);
        end
        cmp++;
        if (a_err_dup !== 1'b0 || a_err_range !== 1'b0 || b_err_dup !== 1'b0 || b_err_range !== 1'b0) begin
            err++;
            $display("FAIL reset_flags: a=%0b%0b b=%0b%0b, required 0",
                     a_err_dup, a_err_range, b_err_dup, b_err_range);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cmp++;
        if (a_s_ready !== 1'b1) begin
            err++;
            $display("FAIL reset_release: s_ready=%0b, required 1", a_s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int dq[$];
        int lq[$];
        int ex[$];
        sel = 1'b0;
        cur_n = 4;
        dq = '{10, 20, 30, 40};
        lq = '{2, 0, 3, 1};
        ex = '{20, 40, 10, 30};
        run_frame(dq, lq, ex, 1'b0, 1'b0, 0, 0, "basic");
    endtask

    task automatic test_bypass();
        int dq[$];
        int lq[$];
        int ex[$];
        dq = '{1, 2, 3, 99};
        lq = '{1, 2, 3, 0};
        ex = '{99, 1, 2, 3};
        run_frame(dq, lq, ex, 1'b0, 1'b0, 0, 0, "bypass");
    endtask

    task automatic test_backpressure();
        int dq[$];
        int lq[$];
        int ex[$];
        dq = '{50, 51, 52, 53};
        lq = '{3, 1, 0, 2};
        ex = '{52, 51, 53, 50};
        run_frame(dq, lq, ex, 1'b0, 1'b0, 0, 5, "backpressure");
    endtask

    task automatic test_dup();
        int dq[$];
        int lq[$];
        int ex[$];
        dq = '{5, 6, 7, 8, 9};
        lq = '{1, 1, 0, 2, 3};
        ex = '{7, 6, 8, 9};
        run_frame(dq, lq, ex, 1'b1, 1'b0, 0, 0, "dup");
    endtask

    task automatic test_random();
        int dq[$];
        int lq[$];
        int perm[4];
        int j;
        int tmp;
        sel = 1'b0;
        cur_n = 4;
        m_dup = 1'b1;
        m_rng = 1'b0;
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 4; i++) perm[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            dq.delete();
            lq.delete();
            for (int i = 0; i < 4; i++) begin
                lq.push_back(perm[i]);
                dq.push_back($urandom_range(0, 255));
            end
            if ($urandom_range(0, 2) == 0) begin
                j = $urandom_range(1, 3);
                lq.insert(j, perm[$urandom_range(0, j - 1)]);
                dq.insert(j, $urandom_range(0, 255));
            end
            ref_frame(dq, lq);
            run_frame(dq, lq, exp_q, m_dup, m_rng, 1, 0, $sformatf("rand%0d", f));
        end
    endtask

    task automatic test_range();
        int dq[$];
        int lq[$];
        int ex[$];
        sel = 1'b1;
        cur_n = 3;
        dq = '{1, 11, 12, 13};
        lq = '{3, 2, 0, 1};
        ex = '{12, 13, 11};
        run_frame(dq, lq, ex, 1'b0, 1'b1, 0, 0, "range");
        sel = 1'b0;
        cur_n = 4;
    endtask

    task automatic test_midreset();
        int dq[$];
        int lq[$];
        int ex[$];
        sel = 1'b0;
        cur_n = 4;
        send(7, 0);
        send(8, 1);
        repeat (3) begin
            @(negedge clk);
            cmp++;
            if (o_m_valid !== 1'b0) begin
                err++;
                $display("FAIL midreset_partial: m_valid=%0b, required 0", o_m_valid);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        cmp++;
        if (o_s_ready !== 1'b0) begin
            err++;
            $display("FAIL midreset_sready: s_ready=%0b during rst, required 0", o_s_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cmp++;
        if (o_m_valid !== 1'b0 || o_err_dup !== 1'b0 || o_err_range !== 1'b0 || o_s_ready !== 1'b1) begin
            err++;
            $display("FAIL midreset_after: valid=%0b dup=%0b rng=%0b s_ready=%0b, required 0/0/0/1",
                     o_m_valid, o_err_dup, o_err_range, o_s_ready);
        end
        @(posedge clk);
        #1;
        dq = '{31, 32, 33, 34};
        lq = '{1, 3, 0, 2};
        ex = '{33, 31, 34, 32};
        run_frame(dq, lq, ex, 1'b0, 1'b0, 0, 0, "midreset");
    endtask

    initial begin
        cur_n = 4;
        m_dup = 1'b0;
        m_rng = 1'b0;
        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_dup();
        test_random();
        test_range();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule

// File: doc/label_unsort_buffer.md
Name: label_unsort_buffer

Overview:
- Inverse of the compare/swap sorting network. It restores sorted results to their original input order.
- Accepts a serial stream of N sorted (data, label) pairs, where label is the original input position. Each pair is written into a buffer slot addressed by its label.
- Once all N slots are filled, the block emits the data in index order 0..N-1 on a valid/ready output stream.
- Sits at the output end of the sorting network, after a parallel-to-serial stage, feeding downstream consumers that need the original order with rank information stripped.

Parameters:
- DATA_WIDTH, 8, width of the data word.
- LABEL_WIDTH, 3, width of the label / original-index field.
- N, 8, number of elements per frame; must satisfy 2 <= N <= 2**LABEL_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input pair valid.
- s_ready  out  1  block can accept an input pair.
- s_data  in  DATA_WIDTH  sorted data word.
- s_label  in  LABEL_WIDTH  original position of s_data.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  DATA_WIDTH  data restored to original order.
- m_index  out  LABEL_WIDTH  original index of m_data.
- m_last  out  1  marks index N-1.
- err_dup  out  1  sticky: a duplicate label was seen in a frame.
- err_range  out  1  sticky: a label >= N was seen.

Behaviour:
- Reset (rst=1 at posedge):
  - state=FILL, occupancy bitmap=0, read pointer=0.
  - m_valid=0, m_data=0, m_index=0, m_last=0, err_dup=0, err_range=0.
  - s_ready is forced to 0 while rst is high.
  - Buffer contents are don't-care. A reset mid-frame or mid-drain discards the partial frame; no output is emitted.
- States: FILL and DRAIN.
- s_ready = (state==FILL) && !rst, combinational.
- Input transfer occurs on s_valid && s_ready at a posedge.
- FILL, label < N and slot free: write mem[label]=s_data and set occ[label].
- FILL, label < N and slot already occupied:
  - Overwrite mem[label] and set err_dup.
  - The occupancy count does not advance; the frame still requires N distinct labels.
- FILL, label >= N: word dropped, no write, err_range set.
- FILL->DRAIN:
  - Taken at the posedge where the accepted write makes occ all-ones.
  - At the same edge: m_valid<=1, m_index<=0, m_last<=(N==1 ? 1 : 0); N>=2, so this is 0.
  - m_data<=mem[0]. If that same write targeted label 0, m_data takes s_data directly (bypass).
  - Latency: m_valid is high in the cycle after the completing input handshake.
- DRAIN:
  - m_data, m_index and m_last are held stable while m_valid && !m_ready.
  - On m_valid && m_ready with m_index < N-1: m_index<=m_index+1, m_data<=mem[m_index+1], m_last<=(m_index+1==N-1).
  - On m_valid && m_ready with m_last=1: m_valid<=0, m_last<=0, m_index<=0, occ<=0, state<=FILL.
  - s_ready rises in the cycle after the final handshake. No overlap between frames; throughput is one frame per 2N cycles minimum.
- Error flags are sticky until rst. They never block the handshake.
- m_index arithmetic uses LABEL_WIDTH bits and never exceeds N-1. There is no wrap beyond N-1.
- Simultaneous s_valid with DRAIN: not accepted (s_ready=0). The upstream holds its data.

Decomposition:
- Shared package/header (sn_defs):
  - FSM state encodings (ST_FILL=0, ST_DRAIN=1).
  - Common DATA_WIDTH/LABEL_WIDTH defaults, shared with the sorting cells.
- One sub-module: unsort_mem.
  - N x DATA_WIDTH register array with one write port and one combinational read port.
  - Parent holds the FSM, occupancy bitmap, bypass mux and output registers.

Test Plan:
- N=4, LABEL_WIDTH=2, m_ready=1.
  - Stimulus: input (10,2),(20,0),(30,3),(40,1).
  - Required: m_data 20,40,10,30 with m_index 0..3, m_last only on the 4th word.
  - Required: first m_valid one cycle after the 4th input handshake.
- Bypass case. Stimulus: last input is (99,0). Required: the first output word is 99, index 0.
- Backpressure. Stimulus: m_ready held low for 5 cycles during drain. Required: m_data/m_index stable; s_ready=0 throughout; drain completes after release.
- Duplicate label. Stimulus: (5,1),(6,1),(7,0),(8,2),(9,3). Required: err_dup=1; output 7,6,8,9.
- Out-of-range, N=3, LABEL_WIDTH=2.
  - Stimulus: (1,3) first.
  - Required: err_range=1, word dropped; the frame completes after labels 0,1,2 arrive.
- Reset mid-frame. Stimulus: rst after 2 of 4 inputs, then a fresh full frame. Required: no output from the partial frame; the new frame outputs correctly; err flags are 0.
